// File: rtl/microsequencer_if.sv
// rtl/microsequencer_if.sv - sequencer control/status bundle between microcode controller and sequencer
interface microsequencer_if #(
    parameter int ADDR_WIDTH  = 6,
    parameter int OP_WIDTH    = 4,
    parameter int COND_WIDTH  = 3,
    parameter int STACK_DEPTH = 4
);
    localparam int NUM_COND = 1 << COND_WIDTH;
    localparam int DEPTH_W  = $clog2(STACK_DEPTH + 1);

    logic                  en;
    logic                  ird;
    logic [COND_WIDTH-1:0] cond;
    logic [ADDR_WIDTH-1:0] j;
    logic [OP_WIDTH-1:0]   opcode;
    logic [NUM_COND-1:0]   qual;
    logic [1:0]            seq_op;
    logic                  err_clr;
    logic [ADDR_WIDTH-1:0] cs;
    logic [ADDR_WIDTH-1:0] ns;
    logic [DEPTH_W-1:0]    depth;
    logic                  stk_ovf;
    logic                  stk_unf;

    modport master (
        output en, ird, cond, j, opcode, qual, seq_op, err_clr,
        input  cs, ns, depth, stk_ovf, stk_unf
    );

    modport slave (
        input  en, ird, cond, j, opcode, qual, seq_op, err_clr,
        output cs, ns, depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - micro-address sequencer with optional call/return stack (MICROSEQUENCER_STACK_EN)
module microsequencer #(
    parameter int ADDR_WIDTH  = 6,
    parameter int OP_WIDTH    = 4,
    parameter int COND_WIDTH  = 3,
    parameter logic [4*(1<<COND_WIDTH)-1:0] COND_MAP = 32'h00430210,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 18
) (
    input  logic             clk,
    input  logic             arst_n,
    microsequencer_if.slave  bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] cs_q;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] ns_c;
    logic [3:0]            map_idx;

    // Map indices at or above ADDR_WIDTH match no bit and are therefore harmless.
    always_comb begin
        base    = '0;
        map_idx = '0;
        if (bus.ird) begin
            base = ADDR_WIDTH'(bus.opcode);
        end else begin
            base = bus.j;
            if ((bus.cond != '0) && bus.qual[bus.cond]) begin
                map_idx = COND_MAP[4*bus.cond +: 4];
                for (int b = 0; b < ADDR_WIDTH; b++) begin
                    if (32'(map_idx) == b) begin
                        base[b] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cs_q <= ADDR_WIDTH'(RESET_ADDR);
        end else if (bus.en) begin
            cs_q <= ns_c;
        end
    end

`ifdef MICROSEQUENCER_STACK_EN
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
    logic [DEPTH_W-1:0]    depth_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  is_call;
    logic                  is_ret;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [IDX_W-1:0]      top_idx;
    logic [IDX_W-1:0]      push_idx;

    assign is_call  = (bus.seq_op == 2'b01);
    assign is_ret   = (bus.seq_op == 2'b10);
    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign push     = bus.en & is_call & ~full;
    assign pop      = bus.en & is_ret & ~empty;
    assign top_idx  = IDX_W'(depth_q - 1'b1);
    assign push_idx = IDX_W'(depth_q);

    // Stack top is read straight from the array; push/pop land on the same edge as cs.
    assign ns_c = is_ret ? (empty ? ADDR_WIDTH'(RESET_ADDR) : stack[top_idx]) : base;

    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= cs_q + 1'b1;
        end
    end

    // A fresh error outranks err_clr in the same cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.en) begin
            if (push) begin
                depth_q <= depth_q + 1'b1;
            end else if (pop) begin
                depth_q <= depth_q - 1'b1;
            end
            ovf_q <= (is_call & full) | (ovf_q & ~bus.err_clr);
            unf_q <= (is_ret & empty) | (unf_q & ~bus.err_clr);
        end
    end

    assign bus.depth   = depth_q;
    assign bus.stk_ovf = ovf_q;
    assign bus.stk_unf = unf_q;
`else
    logic unused_stack_inputs;

    assign unused_stack_inputs = ^{bus.seq_op, bus.err_clr};
    assign ns_c        = base;
    assign bus.depth   = '0;
    assign bus.stk_ovf = 1'b0;
    assign bus.stk_unf = 1'b0;
`endif

    assign bus.cs = cs_q;
    assign bus.ns = ns_c;
endmodule
